fetch_unit: RTL

- Instruction-fetch front end of the 3-stage RV32I pipeline; producer side of the controller's `inst` input.
- Holds the PC and drives the fetch address to the synchronous-read BIOS and IMEM (1-cycle read latency).
- Steers the returned word from the correct memory and presents it to IF/D with its PC.
- Accepts redirects (PCSel + ALU target) from the execute stage and squashes the wrong-path slot with NOP.

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : RV32I instruction-fetch front end. It holds the PC, addresses the
//            BIOS and IMEM (1-cycle read latency), steers the returned word to
//            IF/D and squashes wrong-path slots on a redirect.
//            Optional macro FETCH_CNT_EN adds fetch and kill event counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        pc_sel_i,
    input  logic [31:0] alu_target_i,
    output logic [31:0] fetch_addr_o,
    output logic        bios_en_o,
    input  logic [31:0] bios_dout_i,
    input  logic [31:0] imem_dout_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o,
    output logic        misalign_o
`ifdef FETCH_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] kill_cnt_o
`endif
);

    localparam logic [31:0] C_PC_INIT = RESET_PC - 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_KILL = 2'd2
    } state_t;

    state_t      st_q, st_d;
    logic [31:0] pc_q, next_pc_d;
    logic        src_bios_q;
    logic        misalign_q, misalign_d;
    logic [31:0] raw_w;
    logic        squash_w;

    assign raw_w = src_bios_q ? bios_dout_i : imem_dout_i;

    always_comb begin
        next_pc_d    = pc_q + 32'd4;
        st_d         = st_q;
        misalign_d   = misalign_q;
        inst_o       = NOP_INST;
        inst_valid_o = 1'b0;
        squash_w     = 1'b0;

        if (pc_sel_i) begin
            next_pc_d = {alu_target_i[31:2], 2'b00};
            st_d      = ST_KILL;
            if (alu_target_i[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (stall_i) begin
            next_pc_d = pc_q;
        end else begin
            st_d = ST_RUN;
        end

        // The word on the memory outputs is wrong-path as soon as a redirect shows up.
        if (st_q == ST_RUN) begin
            if (pc_sel_i) begin
                squash_w = 1'b1;
            end else begin
                inst_o       = raw_w;
                inst_valid_o = 1'b1;
            end
        end
    end

    // Memories see the reset PC while reset is held, independent of other inputs.
    assign fetch_addr_o = rst_ni ? next_pc_d : RESET_PC;
    assign bios_en_o    = fetch_addr_o[30];
    assign inst_pc_o    = pc_q;
    assign misalign_o   = misalign_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q       <= C_PC_INIT;
            src_bios_q <= RESET_PC[30];
            st_q       <= ST_BOOT;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= next_pc_d;
            src_bios_q <= next_pc_d[30];
            st_q       <= st_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef FETCH_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] kill_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_cnt_q <= 32'd0;
            kill_cnt_q  <= 32'd0;
        end else begin
            if (inst_valid_o && !stall_i) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (squash_w) begin
                kill_cnt_q <= kill_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign kill_cnt_o  = kill_cnt_q;
`endif

endmodule
`default_nettype wire
